// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one downstream SRAM-like port between the instruction-fetch and
//   data requesters. Requests are arbitrated combinationally. A grant is held
//   while the address handshake stalls. The owner of every accepted
//   transaction is queued in order so that responses are routed back to the
//   requester that issued them.
// Ports
//   clk, resetn            clock, asynchronous active-low reset
//   inst_*                 fetch request (read-only, word size) and response
//   data_*                 load/store request and response
//   m_*                    downstream request, handshake and response
//   busy                   transactions outstanding
//   err                    sticky protocol error (locked requester dropped
//                          its request, or a response arrived with nothing
//                          outstanding)
module mem_port_arbiter #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_cache,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic [31:0] inst_rdata,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_cache,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [2:0]  data_size,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic [31:0] data_rdata,
  output logic        data_data_ok,
  output logic        m_req,
  output logic        m_cache,
  output logic        m_wr,
  output logic [3:0]  m_wstrb,
  output logic [31:0] m_addr,
  output logic [2:0]  m_size,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic [31:0] m_rdata,
  input  logic        m_data_ok,
  output logic        busy,
  output logic        err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    UNLOCKED    = 2'd0,
    LOCKED_INST = 2'd1,
    LOCKED_DATA = 2'd2
  } lock_e;

  lock_e            lock_q, lock_d;
  logic [DEPTH-1:0] owner_q;            // 0 = inst, 1 = data
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic             err_q, err_d;

  logic gnt_data, gnt_req, full, accept, pop, head, lock_drop;

  // Grant: locked owner, then a starved fetch, then data, then fetch.
  always_comb begin
    gnt_data = 1'b0;
    unique case (lock_q)
      LOCKED_INST: gnt_data = 1'b0;
      LOCKED_DATA: gnt_data = 1'b1;
      default: begin
        if (inst_req && (starve_q == LIMIT_C)) gnt_data = 1'b0;
        else                                   gnt_data = data_req;
      end
    endcase
  end

  assign gnt_req = gnt_data ? data_req : inst_req;
  assign full    = (count_q == DEPTH_C);
  assign accept  = m_req && m_addr_ok;
  assign pop     = m_data_ok && (count_q != '0);
  assign head    = owner_q[rd_ptr_q];
  assign busy    = (count_q != '0);
  assign err     = err_q;

  // Lock state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) lock_q <= UNLOCKED;
    else         lock_q <= lock_d;
  end

  // Lock next-state: hold grant across a stalled handshake
  always_comb begin
    lock_d    = lock_q;
    lock_drop = 1'b0;
    unique case (lock_q)
      UNLOCKED: begin
        if (m_req && !m_addr_ok) lock_d = gnt_data ? LOCKED_DATA : LOCKED_INST;
      end
      LOCKED_INST: begin
        if (accept) lock_d = UNLOCKED;
        else if (!inst_req) begin
          lock_d    = UNLOCKED;
          lock_drop = 1'b1;
        end
      end
      LOCKED_DATA: begin
        if (accept) lock_d = UNLOCKED;
        else if (!data_req) begin
          lock_d    = UNLOCKED;
          lock_drop = 1'b1;
        end
      end
      default: lock_d = UNLOCKED;
    endcase
  end

  // Outputs: payload mux, handshakes and response steering
  always_comb begin
    m_req        = gnt_req && !full;
    m_cache      = gnt_data ? data_cache : inst_cache;
    m_addr       = gnt_data ? data_addr  : inst_addr;
    m_wr         = gnt_data ? data_wr    : 1'b0;
    m_wstrb      = gnt_data ? data_wstrb : 4'b0000;
    m_size       = gnt_data ? data_size  : 3'd2;
    m_wdata      = gnt_data ? data_wdata : '0;
    inst_addr_ok = accept && !gnt_data;
    data_addr_ok = accept &&  gnt_data;
    inst_data_ok = pop && !head;
    data_data_ok = pop &&  head;
    inst_rdata   = m_rdata;
    data_rdata   = m_rdata;
  end

  // Owner FIFO, starvation counter and error flag next-state
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop)    rd_ptr_d = rd_ptr_q + AW'(1);
    if (accept) wr_ptr_d = wr_ptr_q + AW'(1);
    unique case ({accept, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase

    starve_d = '0;
    if (inst_req && !(accept && !gnt_data))
      starve_d = (starve_q == LIMIT_C) ? starve_q : starve_q + SW'(1);

    err_d = err_q || lock_drop || (m_data_ok && (count_q == '0));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) owner_q[wr_ptr_q] <= gnt_data;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;

  logic        clk = 1'b0, resetn = 1'b0;
  logic        inst_req = 0, inst_cache = 0;
  logic [31:0] inst_addr = '0;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req = 0, data_cache = 0, data_wr = 0;
  logic [3:0]  data_wstrb = '0;
  logic [31:0] data_addr = '0, data_wdata = '0;
  logic [2:0]  data_size = '0;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        m_req, m_cache, m_wr;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr, m_wdata;
  logic [2:0]  m_size;
  logic        m_addr_ok = 0, m_data_ok = 0;
  logic [31:0] m_rdata = '0;
  logic        busy, err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_cache(inst_cache), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_rdata(inst_rdata), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_cache(data_cache), .data_wr(data_wr),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_size(data_size),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_rdata(data_rdata),
    .data_data_ok(data_data_ok),
    .m_req(m_req), .m_cache(m_cache), .m_wr(m_wr), .m_wstrb(m_wstrb),
    .m_addr(m_addr), .m_size(m_size), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_rdata(m_rdata), .m_data_ok(m_data_ok),
    .busy(busy), .err(err)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: queue of outstanding owners (0 inst, 1 data),
  // held grant (-1 none), fetch-denial count, sticky error.
  bit own_q[$];
  int lock_own = -1;
  int starve   = 0;
  bit err_m    = 0;
  bit last_inst_acc, last_data_acc;
  bit pend_i, pend_d;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    own_q.delete();
    lock_own = -1;
    starve   = 0;
    err_m    = 0;
  endtask

  // Called just after inputs are driven at a negedge; checks outputs,
  // then advances the model across the next rising edge.
  task automatic step();
    int g, n;
    bit greq, mreq, acc, pop, hd;
    #1;
    n = own_q.size();
    if (lock_own >= 0)                             g = lock_own;
    else if (inst_req && starve == STARVE_LIMIT)   g = 0;
    else if (data_req)                             g = 1;
    else                                           g = 0;
    greq = (g == 1) ? data_req : inst_req;
    mreq = greq && (n < DEPTH);
    acc  = mreq && m_addr_ok;
    pop  = m_data_ok && (n > 0);
    hd   = (n > 0) ? own_q[0] : 1'b0;

    check_eq("m_req", m_req, mreq);
    check_eq("inst_addr_ok", inst_addr_ok, acc && g == 0);
    check_eq("data_addr_ok", data_addr_ok, acc && g == 1);
    if (mreq) begin
      check_eq("m_addr",  m_addr,  (g == 1) ? data_addr : inst_addr);
      check_eq("m_wr",    m_wr,    (g == 1) ? data_wr : 1'b0);
      check_eq("m_wstrb", m_wstrb, (g == 1) ? data_wstrb : 4'h0);
      check_eq("m_size",  m_size,  (g == 1) ? data_size : 3'd2);
    end
    check_eq("inst_data_ok", inst_data_ok, pop && !hd);
    check_eq("data_data_ok", data_data_ok, pop && hd);
    if (m_data_ok) begin
      check_eq("inst_rdata", inst_rdata, m_rdata);
      check_eq("data_rdata", data_rdata, m_rdata);
    end
    check_eq("busy", busy, n != 0);
    check_eq("err",  err,  err_m);
    last_inst_acc = acc && g == 0;
    last_data_acc = acc && g == 1;

    @(posedge clk);
    if (pop) void'(own_q.pop_front());
    if (acc) own_q.push_back(g == 1);
    if (m_data_ok && n == 0) err_m = 1;
    if (acc) lock_own = -1;
    else if (lock_own >= 0 && !greq) begin
      lock_own = -1;
      err_m    = 1;
    end else if (mreq) lock_own = g;
    if (inst_req && !(acc && g == 0)) starve = (starve < STARVE_LIMIT) ? starve + 1 : starve;
    else                              starve = 0;
  endtask

  task automatic async_reset();
    #2;
    inst_req = 0; data_req = 0; m_data_ok = 0; m_addr_ok = 0;
    resetn = 0;
    #1;
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_err", err, 1'b0);
    check_eq("rst_m_req", m_req, 1'b0);
    check_eq("rst_data_ok", inst_data_ok | data_data_ok, 1'b0);
    model_reset();
    pend_i = 0; pend_d = 0;
    @(negedge clk);
    resetn = 1;
  endtask

  task automatic rand_cycle(input bit clean);
    if (!pend_i && $urandom_range(0, 99) < 50) begin
      pend_i = 1; inst_addr = $urandom & 32'hFFFF_FFFC; inst_cache = 1'($urandom);
    end
    if (!pend_d && $urandom_range(0, 99) < 50) begin
      pend_d = 1; data_addr = $urandom; data_cache = 1'($urandom);
      data_wr = 1'($urandom); data_wstrb = 4'($urandom);
      data_size = 3'($urandom_range(0, 2)); data_wdata = $urandom;
    end
    if (!clean && pend_i && $urandom_range(0, 99) < 4) pend_i = 0;
    if (!clean && pend_d && $urandom_range(0, 99) < 4) pend_d = 0;
    inst_req  = pend_i;
    data_req  = pend_d;
    m_addr_ok = ($urandom_range(0, 99) < 70);
    m_rdata   = $urandom;
    if (clean) m_data_ok = (own_q.size() > 0) && ($urandom_range(0, 99) < 50);
    else       m_data_ok = ($urandom_range(0, 99) < 40);
    step();
    if (last_inst_acc) pend_i = 0;
    if (last_data_acc) pend_d = 0;
  endtask

  initial begin
    int first;
    #2;
    check_eq("reset_m_req", m_req, 1'b0);
    check_eq("reset_busy", busy, 1'b0);
    check_eq("reset_err", err, 1'b0);
    check_eq("reset_addr_ok", inst_addr_ok | data_addr_ok, 1'b0);
    check_eq("reset_data_ok", inst_data_ok | data_data_ok, 1'b0);
    @(negedge clk); resetn = 1;

    // Single fetch round trip
    @(negedge clk);
    inst_req = 1; inst_addr = 32'hBFC0_0000; m_addr_ok = 1;
    #1;
    check_eq("t1_m_addr", m_addr, 32'hBFC0_0000);
    check_eq("t1_m_wr", m_wr, 1'b0);
    check_eq("t1_inst_addr_ok", inst_addr_ok, 1'b1);
    step();
    @(negedge clk); inst_req = 0; m_addr_ok = 0; step();
    @(negedge clk); m_data_ok = 1; m_rdata = 32'h3C1A_0000;
    #1;
    check_eq("t1_inst_data_ok", inst_data_ok, 1'b1);
    check_eq("t1_inst_rdata", inst_rdata, 32'h3C1A_0000);
    step();
    @(negedge clk); m_data_ok = 0;
    #1; check_eq("t1_busy", busy, 1'b0);
    step();

    // Both request: data first, fetch next; responses in order
    @(negedge clk);
    inst_req = 1; data_req = 1; data_addr = 32'h0000_1000; m_addr_ok = 1;
    #1;
    check_eq("t2_data_first", data_addr_ok, 1'b1);
    check_eq("t2_inst_held", inst_addr_ok, 1'b0);
    step();
    @(negedge clk); data_req = 0;
    #1; check_eq("t2_inst_next", inst_addr_ok, 1'b1);
    step();
    @(negedge clk); inst_req = 0; m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'h1111_2222;
    #1; check_eq("t2_resp_data", data_data_ok, 1'b1);
    step();
    @(negedge clk); m_rdata = 32'h3333_4444;
    #1; check_eq("t2_resp_inst", inst_data_ok, 1'b1);
    step();
    @(negedge clk); m_data_ok = 0; step();

    // Stalled data handshake holds the grant against a later fetch
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      data_req = 1; data_addr = 32'h1000_0040; m_addr_ok = 0;
      if (k >= 1) inst_req = 1;
      #1;
      check_eq("t3_m_addr_held", m_addr, 32'h1000_0040);
      check_eq("t3_no_inst_ok", inst_addr_ok, 1'b0);
      step();
    end
    @(negedge clk); m_addr_ok = 1;
    #1; check_eq("t3_data_accept", data_addr_ok, 1'b1);
    step();
    @(negedge clk); data_req = 0;
    #1; check_eq("t3_inst_accept", inst_addr_ok, 1'b1);
    step();
    @(negedge clk); inst_req = 0; m_addr_ok = 0; m_data_ok = 1; step();
    @(negedge clk); step();
    @(negedge clk); m_data_ok = 0; step();

    // Fetch starvation promotion
    first = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      inst_req = 1; data_req = 1; m_addr_ok = 1; m_data_ok = (k > 0);
      #1;
      if (inst_addr_ok && first < 0) first = k;
      step();
    end
    check_eq("t4_starve_cycle", first, STARVE_LIMIT);
    @(negedge clk); inst_req = 0; data_req = 0; m_addr_ok = 0; m_data_ok = 1; step();
    @(negedge clk); m_data_ok = 0; step();

    // Full FIFO blocks requests until a response frees a slot
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clk); inst_req = 1; m_addr_ok = 1; step();
    end
    @(negedge clk); #1; check_eq("t5_full_blocks", m_req, 1'b0); step();
    @(negedge clk); m_data_ok = 1;
    #1; check_eq("t5_full_pop_cycle", m_req, 1'b0); step();
    @(negedge clk); m_data_ok = 0;
    #1; check_eq("t5_reassert", m_req, 1'b1); step();
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clk); inst_req = 0; m_addr_ok = 0; m_data_ok = 1; step();
    end
    @(negedge clk); m_data_ok = 0; step();

    // Spurious response, sticky error, async reset clears tracking
    @(negedge clk); m_data_ok = 1;
    #1; check_eq("t6_no_resp", inst_data_ok | data_data_ok, 1'b0);
    step();
    @(negedge clk); m_data_ok = 0;
    #1; check_eq("t6_err_set", err, 1'b1);
    step();
    @(negedge clk); step();
    @(negedge clk); #1; check_eq("t6_err_held", err, 1'b1); step();
    @(negedge clk); inst_req = 1; m_addr_ok = 1; step();
    async_reset();
    @(negedge clk); m_data_ok = 1; step();
    @(negedge clk); m_data_ok = 0;
    #1; check_eq("t6_err_after_reset", err, 1'b1);
    step();
    async_reset();

    // Random traffic obeying the handshake rules
    pend_i = 0; pend_d = 0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      rand_cycle(1'b1);
    end
    // Random traffic with protocol violations and resets mid-flight
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      rand_cycle(1'b0);
      if ($urandom_range(0, 99) < 3) async_reset();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
